muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 179 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32x32 multiply / divide unit with HI/LO result registers.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   start, op, x, y : request an operation (op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   kill            : abort the in-flight operation; no result is written
//   wr_hi, wr_lo    : direct writes of wdata into hi/lo while idle
//   busy            : high while an operation is in flight
//   done            : one-cycle pulse on the cycle after hi/lo take a new result
//   hi, lo          : result registers (remainder/upper product, quotient/lower product)
//   dbg_state       : current FSM state, for observation only
//
// Handshake: start is accepted only on an edge where the block is idle and kill
// is low; start presented while busy is ignored, not queued. The result arrives
// 33 edges after acceptance (1 edge for divide-by-zero), marked by done.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        kill,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [4:0]  count_q,  count_d;
    // Working register: multiply keeps {partial product, remaining multiplier},
    // divide keeps {partial remainder, dividend bits / quotient bits}.
    logic [63:0] acc_q,    acc_d;
    // Multiplicand (multiply) or divisor (divide), magnitude only.
    logic [31:0] opnd_q,   opnd_d;
    logic        is_mul_q, is_mul_d;
    logic        neg_hi_q, neg_hi_d;
    logic        neg_lo_q, neg_lo_d;
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;
    logic        done_q,   done_d;

    logic        signed_op;
    logic [31:0] abs_x, abs_y;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] mul_res;

    always_comb begin
        signed_op = op[0];
        abs_x     = (signed_op && x[31]) ? (32'd0 - x) : x;
        abs_y     = (signed_op && y[31]) ? (32'd0 - y) : y;
        // Shift-add: add multiplicand into upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
        // Restoring divide: trial-subtract divisor from the remainder shifted
        // left with the next dividend bit brought in.
        div_diff  = acc_q[63:31] - {1'b0, opnd_q};
        mul_res   = neg_lo_q ? (64'd0 - acc_q) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = 5'd0;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_mul_d = is_mul_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    is_mul_d = ~op[1];
                    if (op[1] && (y == 32'd0)) begin
                        // Divide by zero: result is fixed, skip iteration.
                        acc_d    = {x, 32'hFFFF_FFFF};
                        neg_hi_d = 1'b0;
                        neg_lo_d = 1'b0;
                        state_d  = ST_FIX;
                    end else if (!op[1]) begin
                        acc_d    = {32'd0, abs_y};
                        opnd_d   = abs_x;
                        neg_hi_d = 1'b0;
                        neg_lo_d = signed_op && (x[31] ^ y[31]);
                        state_d  = ST_CALC;
                    end else begin
                        acc_d    = {32'd0, abs_x};
                        opnd_d   = abs_y;
                        neg_hi_d = signed_op && x[31];
                        neg_lo_d = signed_op && (x[31] ^ y[31]);
                        state_d  = ST_CALC;
                    end
                end else if (!start) begin
                    // kill has no effect here, so writes still go through.
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_mul_q) begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end else if (!div_diff[32]) begin
                        acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[62:0], 1'b0};
                    end
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        count_d = 5'd0;
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!kill) begin
                    done_d = 1'b1;
                    if (is_mul_q) begin
                        hi_d = mul_res[63:32];
                        lo_d = mul_res[31:0];
                    end else begin
                        hi_d = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                        lo_d = neg_lo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            is_mul_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_mul_q <= is_mul_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        kill;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int n_tests;
    int n_fail;

    muldiv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .x         (x),
        .y         (y),
        .kill      (kill),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for exactly one edge (edge 0); returns after edge 0 + 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        x     = a;
        y     = b;
        tick();
        start = 1'b0;
    endtask

    // Run one operation, check latency, busy, result and single-cycle done.
    task automatic run_vec(input int idx);
        int n;
        string tag;
        tag = $sformatf("v%0d", idx);
        issue(vecs[idx].op, vecs[idx].x, vecs[idx].y);
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (!done && n < vecs[idx].lat) check({tag, "_busy_mid"}, {63'd0, busy}, 64'd1);
        end
        check({tag, "_lat"}, n, vecs[idx].lat);
        check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, vecs[idx].exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, vecs[idx].exp_lo});
        tick();
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int saw_done;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; x = '0; y = '0;
        kill = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;

        //            op     x             y             hi            lo           lat
        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
        vecs[4]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33};
        vecs[7]  = '{2'b10, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
        vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33};
        vecs[10] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33};
        vecs[11] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[12] = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
        vecs[13] = '{2'b10, 32'h00000003, 32'h00000007, 32'h00000003, 32'h00000000, 33};

        // reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);

        for (int i = 0; i < 14; i++) run_vec(i);

        // MTHI/MTLO: both strobes, then hi alone
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h11111111;
        tick();
        wr_hi = 1'b1; wr_lo = 1'b0; wdata = 32'hA5A5A5A5;
        tick();
        wr_hi = 1'b0;
        check("wr_both_lo", {32'd0, lo}, {32'd0, 32'h11111111});
        check("wr_hi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});

        // write alongside start is dropped
        @(negedge clk);
        wr_lo = 1'b1; wdata = 32'hDEADBEEF; start = 1'b1; op = 2'b00; x = 32'd2; y = 32'd3;
        tick();
        wr_lo = 1'b0; start = 1'b0;
        check("wr_with_start_lo", {32'd0, lo}, {32'd0, 32'h11111111});
        // edge 0 was the tick above; start and write during busy must be ignored
        tick();
        @(negedge clk);
        start = 1'b1; op = 2'b10; x = 32'd9; y = 32'd0; wr_lo = 1'b1; wdata = 32'h0BAD0BAD;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        for (int i = 3; i < 10; i++) tick();
        check("kill_pre_busy", {63'd0, busy}, 64'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy", {63'd0, busy}, 64'd0);
        check("kill_hi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
        check("kill_lo", {32'd0, lo}, {32'd0, 32'h11111111});
        saw_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) saw_done++;
        end
        check("kill_quiet", saw_done, 0);

        // kill and start together in idle: start dropped
        @(negedge clk);
        kill = 1'b1; start = 1'b1; op = 2'b00; x = 32'd5; y = 32'd5;
        tick();
        kill = 1'b0; start = 1'b0;
        check("kill_start_busy", {63'd0, busy}, 64'd0);

        // kill while in FIX: no write, no done
        issue(2'b00, 32'd4, 32'd4);
        for (int i = 1; i <= 32; i++) tick();
        check("fix_state", {62'd0, dbg_state}, 64'd2);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("fix_kill_done", {63'd0, done}, 64'd0);
        check("fix_kill_busy", {63'd0, busy}, 64'd0);
        check("fix_kill_hi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});

        // reset at edge 20 of a DIV
        issue(2'b11, 32'd1000, 32'd3);
        for (int i = 1; i < 20; i++) tick();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_hi", {32'd0, hi}, 64'd0);
        check("mid_rst_lo", {32'd0, lo}, 64'd0);
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) saw_done++;
        end
        check("mid_rst_no_done", saw_done, 0);

        // block still operational after the reset
        run_vec(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
